// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for alternating priority; default is fixed load/store-over-fetch.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_read_i,
  input  logic [31:0] ls_read_addr_i,
  input  logic [3:0]  ls_write_enable_i,
  input  logic [31:0] ls_write_addr_i,
  input  logic [31:0] ls_write_data_i,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        stall_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_t;

  state_t state, state_next;
  logic   ls_is_read;
  logic   ls_req;
  logic   ls_store;
  logic   window;
  logic   ls_win;
  logic   if_win;

  assign ls_store = |ls_write_enable_i;
  assign ls_req   = ls_read_i | ls_store;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when the most recent grant went to the load/store side.
  logic last_ls;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_ls <= 1'b0;
    end else if (ls_win) begin
      last_ls <= 1'b1;
    end else if (if_win) begin
      last_ls <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    window     = 1'b0;
    ls_win     = 1'b0;
    if_win     = 1'b0;
    if_gnt_o   = 1'b0;
    stall_o    = 1'b0;

    // A busy port can only be handed over in its completion cycle.
    window = (state == IDLE) || mem_ready_i;

`ifdef ARB_ROUND_ROBIN_EN
    ls_win = window && ls_req && (!if_req_i || !last_ls);
`else
    ls_win = window && ls_req;
`endif
    if_win = window && if_req_i && !ls_win;

    if_gnt_o = if_win;
    stall_o  = (ls_req && !ls_win) || ((state == BUSY_LS) && !mem_ready_i);

    if (ls_win) begin
      state_next = BUSY_LS;
    end else if (if_win) begin
      state_next = BUSY_IF;
    end else if ((state != IDLE) && mem_ready_i) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en_o    <= 1'b0;
      mem_we_o    <= 4'd0;
      mem_addr_o  <= 32'd0;
      mem_wdata_o <= 32'd0;
      ls_is_read  <= 1'b0;
    end else if (ls_win) begin
      mem_en_o    <= 1'b1;
      mem_we_o    <= ls_write_enable_i;
      mem_addr_o  <= ls_store ? ls_write_addr_i : ls_read_addr_i;
      mem_wdata_o <= ls_store ? ls_write_data_i : 32'd0;
      ls_is_read  <= !ls_store;
    end else if (if_win) begin
      mem_en_o    <= 1'b1;
      mem_we_o    <= 4'd0;
      mem_addr_o  <= if_addr_i;
      mem_wdata_o <= 32'd0;
    end else if ((state != IDLE) && mem_ready_i) begin
      mem_en_o    <= 1'b0;
      mem_we_o    <= 4'd0;
      mem_addr_o  <= 32'd0;
      mem_wdata_o <= 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_rvalid_o <= 1'b0;
      ls_rvalid_o <= 1'b0;
      if_rdata_o  <= 32'd0;
      ls_rdata_o  <= 32'd0;
    end else begin
      if_rvalid_o <= (state == BUSY_IF) && mem_ready_i;
      ls_rvalid_o <= (state == BUSY_LS) && mem_ready_i && ls_is_read;
      if ((state == BUSY_IF) && mem_ready_i) begin
        if_rdata_o <= mem_rdata_i;
      end
      if ((state == BUSY_LS) && mem_ready_i && ls_is_read) begin
        ls_rdata_o <= mem_rdata_i;
      end
    end
  end

endmodule
